// File: rtl/activation_engine_pkg.sv
// Shared definitions for the activation engine: mode encodings and FSM states.
package activation_pkg;

    localparam logic [1:0] ACT_IDENT = 2'b00;
    localparam logic [1:0] ACT_RELU  = 2'b01;
    localparam logic [1:0] ACT_LEAKY = 2'b10;
    localparam logic [1:0] ACT_CLIP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/activation_engine_if.sv
// Request/result bundle between the accumulator array, the activation engine and writeback.
interface activation_engine_if #(
    parameter int NUM_ELEMENTS = 16,
    parameter int DATA_WIDTH   = 16
);
    localparam int SAT_W = $clog2(NUM_ELEMENTS + 1);

    logic                               start;
    logic [1:0]                         mode;
    logic [DATA_WIDTH-1:0]              clip_val;
    logic [NUM_ELEMENTS*DATA_WIDTH-1:0] in;
    logic [NUM_ELEMENTS*DATA_WIDTH-1:0] out;
    logic                               busy;
    logic                               done;
    logic [SAT_W-1:0]                   sat_count;

    modport master (output start, mode, clip_val, in,
                    input  out, busy, done, sat_count);
    modport slave  (input  start, mode, clip_val, in,
                    output out, busy, done, sat_count);
endinterface

// File: rtl/activation_engine_lane.sv
// One element of the activation datapath: purely combinational x -> y plus a clamp flag.
module activation_lane
    import activation_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic        [1:0]            mode,
    input  logic signed [DATA_WIDTH-1:0] clip_val,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         sat
);
    logic signed [DATA_WIDTH-1:0] bound_s;

    // Select the activation; a negative clip bound collapses to zero.
    always_comb begin
        y       = x;
        sat     = 1'b0;
        bound_s = clip_val[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : clip_val;
        case (mode)
            ACT_IDENT: y = x;
            ACT_RELU: begin
                if (x[DATA_WIDTH-1]) y = {DATA_WIDTH{1'b0}};
                else                 y = x;
            end
            ACT_LEAKY: begin
                if (x[DATA_WIDTH-1]) y = x >>> LEAK_SHIFT;
                else                 y = x;
            end
            ACT_CLIP: begin
                if (x[DATA_WIDTH-1]) begin
                    y = {DATA_WIDTH{1'b0}};
                end else if (x > bound_s) begin
                    y   = bound_s;
                    sat = 1'b1;
                end else begin
                    y = x;
                end
            end
            default: y = x;
        endcase
    end
endmodule

// File: rtl/activation_engine.sv
// Multi-lane activation engine: snapshots a vector on start and writes LANES results per beat.
module activation_engine
    import activation_pkg::*;
#(
    parameter int NUM_ELEMENTS = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 8,
    parameter int LANES        = 4,
    parameter int LEAK_SHIFT   = 3
) (
    input  logic          clk,
    input  logic          reset,
    activation_engine_if.slave bus
);
    localparam int BEATS      = NUM_ELEMENTS / LANES;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SAT_W      = $clog2(NUM_ELEMENTS + 1);
    localparam int LANE_SAT_W = $clog2(LANES + 1);
    localparam int VEC_W      = NUM_ELEMENTS * DATA_WIDTH;

    generate
        if ((NUM_ELEMENTS % LANES) != 0) begin : g_bad_lanes
            $error("activation_engine: NUM_ELEMENTS must be a multiple of LANES");
        end
        if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
            $error("activation_engine: FRAC_BITS must be smaller than DATA_WIDTH");
        end
    endgenerate

    state_t                  state_r, next_s;
    logic [BEAT_W-1:0]       beat_r;
    logic [VEC_W-1:0]        snap_in_r;
    logic [1:0]              snap_mode_r;
    logic [DATA_WIDTH-1:0]   snap_clip_r;
    logic [VEC_W-1:0]        out_r;
    logic [SAT_W-1:0]        sat_r;
    logic                    busy_r, done_r;
    logic                    last_beat_s;
    logic [LANE_SAT_W-1:0]   beat_sat_s;

    logic signed [DATA_WIDTH-1:0] lane_x_s [LANES];
    logic signed [DATA_WIDTH-1:0] lane_y_s [LANES];
    logic                         lane_sat_s [LANES];

    assign last_beat_s = (beat_r == BEAT_W'(BEATS - 1));

    // Route the current beat's slice of the snapshot to the lanes and tally clamps.
    always_comb begin
        beat_sat_s = {LANE_SAT_W{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            lane_x_s[l] = snap_in_r[(int'(beat_r) * LANES + l) * DATA_WIDTH +: DATA_WIDTH];
            beat_sat_s  = beat_sat_s + LANE_SAT_W'(lane_sat_s[l]);
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            activation_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .LEAK_SHIFT (LEAK_SHIFT)
            ) u_lane (
                .x        (lane_x_s[g]),
                .mode     (snap_mode_r),
                .clip_val (snap_clip_r),
                .y        (lane_y_s[g]),
                .sat      (lane_sat_s[g])
            );
        end
    endgenerate

    // Next-state logic; DONE always falls back to IDLE so start is never queued.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) next_s = ST_RUN;
                else           next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_beat_s) next_s = ST_DONE;
                else             next_s = ST_RUN;
            end
            ST_DONE: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // State, snapshot, result and saturation registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            beat_r      <= {BEAT_W{1'b0}};
            snap_in_r   <= {VEC_W{1'b0}};
            snap_mode_r <= 2'b00;
            snap_clip_r <= {DATA_WIDTH{1'b0}};
            out_r       <= {VEC_W{1'b0}};
            sat_r       <= {SAT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s == ST_RUN);
            done_r  <= (next_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        snap_in_r   <= bus.in;
                        snap_mode_r <= bus.mode;
                        snap_clip_r <= bus.clip_val;
                        beat_r      <= {BEAT_W{1'b0}};
                        sat_r       <= {SAT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        out_r[(int'(beat_r) * LANES + l) * DATA_WIDTH +: DATA_WIDTH] <= lane_y_s[l];
                    end
                    sat_r  <= sat_r + SAT_W'(beat_sat_s);
                    beat_r <= last_beat_s ? {BEAT_W{1'b0}} : beat_r + BEAT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.out       = out_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.sat_count = sat_r;
endmodule

// File: tb/tb_activation_engine.sv
// Self-checking bench: directed vector table, random runs against a reference model, corner sequences and a LANES sweep.
module tb_activation_engine;
    localparam int NE = 16;
    localparam int DW = 16;
    localparam int VW = NE * DW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    activation_engine_if #(.NUM_ELEMENTS(NE), .DATA_WIDTH(DW)) bus0 ();
    activation_engine_if #(.NUM_ELEMENTS(NE), .DATA_WIDTH(DW)) bus1 ();
    activation_engine_if #(.NUM_ELEMENTS(NE), .DATA_WIDTH(DW)) bus2 ();
    activation_engine_if #(.NUM_ELEMENTS(NE), .DATA_WIDTH(DW)) bus3 ();

    activation_engine #(.NUM_ELEMENTS(NE), .DATA_WIDTH(DW), .FRAC_BITS(8), .LANES(4),  .LEAK_SHIFT(3))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    activation_engine #(.NUM_ELEMENTS(NE), .DATA_WIDTH(DW), .FRAC_BITS(8), .LANES(1),  .LEAK_SHIFT(3))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    activation_engine #(.NUM_ELEMENTS(NE), .DATA_WIDTH(DW), .FRAC_BITS(8), .LANES(2),  .LEAK_SHIFT(3))
        dut2 (.clk(clk), .reset(reset), .bus(bus2));
    activation_engine #(.NUM_ELEMENTS(NE), .DATA_WIDTH(DW), .FRAC_BITS(8), .LANES(16), .LEAK_SHIFT(3))
        dut3 (.clk(clk), .reset(reset), .bus(bus3));

    typedef struct {
        logic [1:0]    mode;
        logic [DW-1:0] clip;
        logic [VW-1:0] vin;
        logic [VW-1:0] vexp;
        int            sat;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int k = 0; k < VW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: per-element rules in plain integer arithmetic; leaky divides by 8 with floor.
    function automatic logic [VW-1:0] model(input logic [1:0] m, input logic [DW-1:0] c,
                                            input logic [VW-1:0] v, output int sat);
        logic [VW-1:0] r;
        int x, cv, bound, y;
        sat = 0;
        r   = '0;
        cv  = $signed(c);
        bound = (cv < 0) ? 0 : cv;
        for (int i = 0; i < NE; i++) begin
            x = $signed(v[i*DW +: DW]);
            case (m)
                2'd0: y = x;
                2'd1: y = (x < 0) ? 0 : x;
                2'd2: y = (x < 0) ? (x - 7) / 8 : x;
                default: begin
                    if (x < 0) y = 0;
                    else if (x > bound) begin y = bound; sat++; end
                    else y = x;
                end
            endcase
            r[i*DW +: DW] = y[DW-1:0];
        end
        return r;
    endfunction

    // One run on the 4-lane instance; optionally re-pulses start mid-run with new data.
    task automatic run0(input string name, input logic [1:0] m, input logic [DW-1:0] c,
                        input logic [VW-1:0] v, input logic [VW-1:0] exp_out, input int exp_sat,
                        input bit inject);
        int cyc;
        int extra;
        bit seen;
        @(negedge clk);
        bus0.start = 1'b1; bus0.mode = m; bus0.clip_val = c; bus0.in = v;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus0.start = 1'b0;
                bus0.in = rand_vec();
                bus0.mode = 2'($urandom);
                bus0.clip_val = DW'($urandom);
                check({name, "_busy_run"}, VW'(bus0.busy), VW'(1));
            end
            if (inject && cyc == 2) begin bus0.start = 1'b1; bus0.in = rand_vec(); end
            if (inject && cyc == 3) bus0.start = 1'b0;
            if (bus0.done) seen = 1'b1;
        end
        check({name, "_latency"}, VW'(cyc), VW'(5));
        check({name, "_out"}, bus0.out, exp_out);
        check({name, "_sat"}, VW'(bus0.sat_count), VW'(exp_sat));
        check({name, "_busy_done"}, VW'(bus0.busy), VW'(0));
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus0.done) extra++;
        end
        check({name, "_single_done"}, VW'(extra), VW'(0));
        check({name, "_out_hold"}, bus0.out, exp_out);
        check({name, "_sat_hold"}, VW'(bus0.sat_count), VW'(exp_sat));
    endtask

    vec_t          tbl[6];
    logic [VW-1:0] vi, ve, v, e;
    logic [DW-1:0] c;
    logic [1:0]    m;
    int            s;
    int            lat[3];
    logic [2:0]    dn;

    initial begin
        bus0.start = 1'b0; bus0.mode = 2'b00; bus0.clip_val = '0; bus0.in = '0;
        bus1.start = 1'b0; bus1.mode = 2'b00; bus1.clip_val = '0; bus1.in = '0;
        bus2.start = 1'b0; bus2.mode = 2'b00; bus2.clip_val = '0; bus2.in = '0;
        bus3.start = 1'b0; bus3.mode = 2'b00; bus3.clip_val = '0; bus3.in = '0;
        reset = 1'b1;

        for (int i = 0; i < NE; i++) begin
            vi[i*DW +: DW] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
            ve[i*DW +: DW] = (i % 2 == 0) ? 16'h0100 : 16'h0000;
        end
        tbl[0] = '{2'b01, 16'h0000, vi, ve, 0};
        for (int i = 0; i < NE; i++) begin
            vi[i*DW +: DW] = (i % 3 == 0) ? 16'hFFF0 : (i % 3 == 1) ? 16'hFFFF : 16'h0040;
            ve[i*DW +: DW] = (i % 3 == 0) ? 16'hFFFE : (i % 3 == 1) ? 16'hFFFF : 16'h0040;
        end
        tbl[1] = '{2'b10, 16'h0000, vi, ve, 0};
        for (int i = 0; i < NE; i++) begin
            vi[i*DW +: DW] = (i < 3) ? 16'h0800 : (i == 3) ? 16'h0300 : (i == 4) ? 16'hFF00 : 16'h0600;
            ve[i*DW +: DW] = (i < 3) ? 16'h0600 : (i == 3) ? 16'h0300 : (i == 4) ? 16'h0000 : 16'h0600;
        end
        tbl[2] = '{2'b11, 16'h0600, vi, ve, 3};
        for (int i = 0; i < NE; i++) begin
            vi[i*DW +: DW] = (i < 8) ? 16'h0010 + 16'(i) : (i == 8) ? 16'h0000 : 16'hFFF0;
            ve[i*DW +: DW] = 16'h0000;
        end
        tbl[3] = '{2'b11, 16'hFF00, vi, ve, 8};
        for (int i = 0; i < NE; i++) begin
            vi[i*DW +: DW] = 16'h7FFF;
            ve[i*DW +: DW] = 16'h7FFF;
        end
        tbl[4] = '{2'b01, 16'h0001, vi, ve, 0};
        for (int i = 0; i < NE; i++) begin
            vi[i*DW +: DW] = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
            ve[i*DW +: DW] = (i % 2 == 0) ? 16'hF000 : 16'h7FFF;
        end
        tbl[5] = '{2'b10, 16'h0000, vi, ve, 0};

        repeat (3) @(negedge clk);
        check("reset_out", bus0.out, '0);
        check("reset_busy", VW'(bus0.busy), VW'(0));
        check("reset_done", VW'(bus0.done), VW'(0));
        check("reset_sat", VW'(bus0.sat_count), VW'(0));
        reset = 1'b0;

        foreach (tbl[t]) run0($sformatf("tbl%0d", t), tbl[t].mode, tbl[t].clip, tbl[t].vin,
                              tbl[t].vexp, tbl[t].sat, 1'b0);

        run0("start_ignored", tbl[2].mode, tbl[2].clip, tbl[2].vin, tbl[2].vexp, tbl[2].sat, 1'b1);

        for (int r = 0; r < 24; r++) begin
            m = 2'($urandom);
            c = (r % 3 == 0) ? DW'($urandom) : DW'($urandom_range(0, 16'h3000));
            v = rand_vec();
            v[0 +: DW] = c;
            e = model(m, c, v, s);
            run0($sformatf("rand%0d", r), m, c, v, e, s, 1'b0);
        end

        // Reset in the middle of a run, just after beat 2 has been written.
        @(negedge clk);
        bus0.start = 1'b1; bus0.mode = 2'b11; bus0.clip_val = 16'h0100; bus0.in = rand_vec();
        @(negedge clk); bus0.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_out", bus0.out, '0);
        check("midreset_busy", VW'(bus0.busy), VW'(0));
        check("midreset_done", VW'(bus0.done), VW'(0));
        check("midreset_sat", VW'(bus0.sat_count), VW'(0));
        @(negedge clk); reset = 1'b0;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus0.done || bus0.busy) s++;
        end
        check("midreset_quiet", VW'(s), VW'(0));
        v = rand_vec();
        e = model(2'b10, 16'h0000, v, s);
        run0("after_reset", 2'b10, 16'h0000, v, e, s, 1'b0);

        // LANES sweep: identity mode, latency NUM_ELEMENTS/LANES+1.
        for (int r = 0; r < 2; r++) begin
            v = rand_vec();
            @(negedge clk);
            bus1.start = 1'b1; bus1.mode = 2'b00; bus1.clip_val = DW'($urandom); bus1.in = v;
            bus2.start = 1'b1; bus2.mode = 2'b00; bus2.clip_val = DW'($urandom); bus2.in = v;
            bus3.start = 1'b1; bus3.mode = 2'b00; bus3.clip_val = DW'($urandom); bus3.in = v;
            lat = '{0, 0, 0};
            for (int cyc = 1; cyc <= 30; cyc++) begin
                @(negedge clk);
                if (cyc == 1) begin
                    bus1.start = 1'b0; bus2.start = 1'b0; bus3.start = 1'b0;
                    bus1.in = rand_vec(); bus2.in = rand_vec(); bus3.in = rand_vec();
                end
                dn = {bus3.done, bus2.done, bus1.done};
                for (int k = 0; k < 3; k++) if (dn[k] && lat[k] == 0) lat[k] = cyc;
            end
            check($sformatf("sweep%0d_lat_l1", r),  VW'(lat[0]), VW'(17));
            check($sformatf("sweep%0d_lat_l2", r),  VW'(lat[1]), VW'(9));
            check($sformatf("sweep%0d_lat_l16", r), VW'(lat[2]), VW'(2));
            check($sformatf("sweep%0d_out_l1", r),  bus1.out, v);
            check($sformatf("sweep%0d_out_l2", r),  bus2.out, v);
            check($sformatf("sweep%0d_out_l16", r), bus3.out, v);
            check($sformatf("sweep%0d_sat_l16", r), VW'(bus3.sat_count), VW'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/activation_engine.md
# activation_engine

Parametrised, multi-lane fixed-point activation engine for the accelerator datapath. It sits between the MAC/accumulator array and the result writeback path. It snapshots a vector of `NUM_ELEMENTS` signed elements on `start` and applies one of four activation functions, processing `LANES` elements per cycle. It then presents the full result vector with a one-cycle `done` pulse and a count of saturated elements.

## Interface
- `NUM_ELEMENTS`, 16: elements per vector; must be a multiple of `LANES`.
- `DATA_WIDTH`, 16: element width, signed two's complement, Q(`DATA_WIDTH-FRAC_BITS`).`FRAC_BITS`.
- `FRAC_BITS`, 8: fractional bits. Documentation only; the arithmetic is format-agnostic.
- `LANES`, 4: elements processed per cycle; BEATS = `NUM_ELEMENTS/LANES`.
- `LEAK_SHIFT`, 3: arithmetic right-shift applied to negatives in leaky mode.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clock `clk`.
- `start`  in  1  request; sampled only in IDLE.
- `mode`  in  2  00 identity, 01 ReLU, 10 leaky ReLU, 11 clipped ReLU; latched at start.
- `clip_val`  in  DATA_WIDTH  signed upper bound for mode 11; latched at start.
- `in`  in  NUM_ELEMENTS*DATA_WIDTH  input vector; element i at bits [i*DATA_WIDTH +: DATA_WIDTH]; latched at start.
- `out`  out  NUM_ELEMENTS*DATA_WIDTH  result vector, same packing.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; `out` and `sat_count` are valid from this cycle on.
- `sat_count`  out  $clog2(NUM_ELEMENTS+1)  number of elements clamped by `clip_val` in the last run.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`: snapshot `in`, `mode`, `clip_val`; set beat=0; clear `sat_count`.
  - In RUN, each edge writes lanes [beat*LANES +: LANES] of `out` and increments beat.
  - RUN→DONE on the edge that writes beat BEATS-1.
  - DONE→IDLE unconditionally.
- Per-element function, x signed:
  - 00: y=x.
  - 01: y = x<0 ? 0 : x.
  - 10: y = x<0 ? x>>>LEAK_SHIFT (arithmetic, floor rounding) : x.
  - 11: y = x<0 ? 0 : (x>clip_val ? clip_val : x).
- Mode 11 with negative `clip_val`: effective upper bound is 0. All outputs are 0, and every x>0 counts as saturated.
- `sat_count` increments by the number of lanes clamped to the upper bound in each beat. It counts only in mode 11 and is 0 in all other modes.
- `start` while in RUN or DONE is ignored and not queued.
- Changes on `in`, `mode` or `clip_val` after the start edge have no effect on the current run.
- `out` and `sat_count` hold their values after DONE until the next accepted `start`. At that point `sat_count` clears; `out` is overwritten beat by beat.
- Reset (including mid-run): state=IDLE, beat=0, `out`=0, `busy`=0, `done`=0, `sat_count`=0. Snapshot registers are cleared.

## Timing
- Start accepted at edge E0. `busy`=1 during cycles E0..E0+BEATS. `done`=1 for the single cycle after edge E0+BEATS. `out` is complete at that point.
- Latency from start to done: BEATS+1 cycles. With defaults: 4 beats, `done` high 5 cycles after the start edge.
- Minimum start-to-start interval: BEATS+2 cycles, because DONE must pass through IDLE.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Package `activation_pkg` holds:
  - the mode encodings as localparams: ACT_IDENT, ACT_RELU, ACT_LEAKY, ACT_CLIP;
  - the FSM state enum.
- Sub-module `activation_lane`: combinational; signed x, mode, clip_val → y and a saturated flag. Instantiated `LANES` times.
- Top level contains the FSM, beat counter, snapshot registers, output register array and saturation accumulator.
- Elaboration check: `NUM_ELEMENTS % LANES == 0`.

## Test plan
- Mode 01, defaults. Inputs alternate 0x0100, 0xFF00 → outputs alternate 0x0100, 0x0000. `done` arrives 5 cycles after start; `sat_count`=0.
- Mode 10. Inputs 0xFFF0, 0xFFFF, 0x0040 → 0xFFFE, 0xFFFF, 0x0040.
- Mode 11, `clip_val`=0x0600. Inputs 0x0800 ×3, 0x0300, 0xFF00, rest 0x0600 → 0x0600, 0x0300, 0x0000, 0x0600. `sat_count`=3; x equal to clip is not counted.
- Start pulsed again during RUN, with `in` changed after the start edge → ignored. Output matches the first snapshot; exactly one `done` pulse.
- Reset asserted at beat 2, then released → all outputs 0, `busy`=0, no `done`. A new start then completes normally.
- Parameter sweep LANES=1, 2, 16 with mode 00 on random data → `out`==`in`. `done` latency is NUM_ELEMENTS/LANES+1.
